// File: rtl/fft_frame_ctrl_if.sv
// Stream bundle around the FFT frame controller: the sample input stream
// (s_*) and the bin output stream (m_*).
// master: the system side that sources samples and sinks bins.
// slave : the frame controller itself.
interface fft_frame_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 10
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_re;
  logic signed [DATA_W-1:0] s_im;

  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_re;
  logic signed [DATA_W-1:0] m_im;
  logic [LOG2N-1:0]         m_index;
  logic                     m_last;

  modport master (
    output s_valid, s_re, s_im, m_ready,
    input  s_ready, m_valid, m_re, m_im, m_index, m_last
  );

  modport slave (
    input  s_valid, s_re, s_im, m_ready,
    output s_ready, m_valid, m_re, m_im, m_index, m_last
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame controller for a streaming FFT core with clock-enable. Loads one
// frame of N = 2^LOG2N samples into the core, flushes its pipeline, captures
// the N output bins into a local RAM and replays them downstream with bin
// index and end-of-frame marker, optionally in bit-reversed address order.
module fft_frame_ctrl #(
  parameter int DATA_W   = 16,
  parameter int LOG2N    = 10,
  parameter int CORE_LAT = 10,
  parameter int BITREV   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  fft_frame_ctrl_if.slave          bus,
  output logic                     core_enable,
  output logic signed [DATA_W-1:0] core_xb_re,
  output logic signed [DATA_W-1:0] core_xb_im,
  input  logic signed [DATA_W-1:0] core_Xb_re,
  input  logic signed [DATA_W-1:0] core_Xb_im,
  output logic                     busy,
  output logic [15:0]              frame_count
);

  localparam int N     = 1 << LOG2N;
  localparam int LAT_W = $clog2(CORE_LAT + 1);
  // One spare bit so the drain read counter can park at N.
  localparam int CNT_W = ((LOG2N > LAT_W) ? LOG2N : LAT_W) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_N     = CNT_W'(N);
  localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(CORE_LAT);
  localparam logic [LOG2N-1:0] IDX_LAST  = '1;

  typedef enum logic [1:0] {LOAD, FLUSH, CAPTURE, DRAIN} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         cnt;

  logic                     hs_in;
  logic                     hs_last_out;
  logic                     pipe_adv;
  logic                     rd_issue;
  logic [LOG2N-1:0]         rd_idx;
  logic [LOG2N-1:0]         rd_addr;

  logic                     s_ready_nxt;
  logic                     core_enable_nxt;
  logic signed [DATA_W-1:0] core_xb_re_nxt;
  logic signed [DATA_W-1:0] core_xb_im_nxt;

  logic [2*DATA_W-1:0]      mem [N];
  logic [2*DATA_W-1:0]      rdata_p0;
  logic                     vld_p0;
  logic [LOG2N-1:0]         idx_p0;
  logic                     last_p0;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign hs_in       = bus.s_valid & bus.s_ready;
  assign hs_last_out = bus.m_valid & bus.m_ready & bus.m_last;
  // The whole read pipe (RAM output and bin register) moves together; it
  // only freezes while a presented beat is being refused.
  assign pipe_adv    = !bus.m_valid || bus.m_ready;
  assign rd_issue    = (state == DRAIN) && (cnt != CNT_N) && pipe_adv;
  assign rd_idx      = cnt[LOG2N-1:0];
  assign rd_addr     = (BITREV != 0) ? bit_rev(rd_idx) : rd_idx;

  assign busy = (state != LOAD) || (cnt != '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state decode. FLUSH lasts CORE_LAT+1 cycles because the core sees
  // sample N-1 one cycle after the state changes (registered core inputs).
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (hs_in && cnt == CNT_LAST) state_nxt = FLUSH;
      FLUSH:   if (cnt == FLUSH_END)         state_nxt = CAPTURE;
      CAPTURE: if (cnt == CNT_LAST)          state_nxt = DRAIN;
      DRAIN:   if (hs_last_out)              state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Output decode: values the registered core/input-side outputs take next.
  always_comb begin
    s_ready_nxt     = 1'b0;
    core_enable_nxt = 1'b0;
    core_xb_re_nxt  = '0;
    core_xb_im_nxt  = '0;
    unique case (state)
      LOAD: begin
        s_ready_nxt     = (state_nxt == LOAD);
        core_enable_nxt = hs_in;
        if (hs_in) begin
          core_xb_re_nxt = bus.s_re;
          core_xb_im_nxt = bus.s_im;
        end
      end
      FLUSH:   core_enable_nxt = 1'b1;
      CAPTURE: core_enable_nxt = (state_nxt == CAPTURE);
      DRAIN:   s_ready_nxt     = (state_nxt == LOAD);
      default: ;
    endcase
  end

  // Phase counter: samples taken, flush cycles, capture address, reads issued.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (state_nxt != state)
      cnt <= '0;
    else if ((state == LOAD && hs_in) || state == FLUSH || state == CAPTURE || rd_issue)
      cnt <= cnt + CNT_W'(1);
  end

  // Registered input-side outputs: s_ready and the core feed.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s_ready <= 1'b0;
      core_enable <= 1'b0;
      core_xb_re  <= '0;
      core_xb_im  <= '0;
    end else begin
      bus.s_ready <= s_ready_nxt;
      core_enable <= core_enable_nxt;
      core_xb_re  <= core_xb_re_nxt;
      core_xb_im  <= core_xb_im_nxt;
    end
  end

  // Bin buffer: capture writes address j on capture cycle j; drain reads
  // are registered (stage p0).
  always_ff @(posedge clk) begin
    if (state == CAPTURE) mem[cnt[LOG2N-1:0]] <= {core_Xb_re, core_Xb_im};
    if (rd_issue)         rdata_p0 <= mem[rd_addr];
  end

  // ---- stage p0: RAM read in flight, index and last travel alongside ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      idx_p0  <= '0;
      last_p0 <= 1'b0;
    end else if (pipe_adv) begin
      vld_p0  <= rd_issue;
      idx_p0  <= rd_idx;
      last_p0 <= (rd_idx == IDX_LAST);
    end
  end

  // ---- stage p1: downstream output register, holds while stalled ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_valid <= 1'b0;
      bus.m_re    <= '0;
      bus.m_im    <= '0;
      bus.m_index <= '0;
      bus.m_last  <= 1'b0;
    end else if (pipe_adv) begin
      bus.m_valid <= vld_p0;
      bus.m_last  <= vld_p0 && last_p0;
      if (vld_p0) begin
        bus.m_re    <= rdata_p0[2*DATA_W-1:DATA_W];
        bus.m_im    <= rdata_p0[DATA_W-1:0];
        bus.m_index <= idx_p0;
      end
    end
  end

  // Completed-frame counter, bumped on the last-beat handshake.
  always_ff @(posedge clk) begin
    if (rst)              frame_count <= '0;
    else if (hs_last_out) frame_count <= frame_count + 16'd1;
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: default-size instance plus a LOG2N=3 bit-reversed
// instance, each driven into an enable-gated delay-line core stand-in.
`timescale 1ns/1ps
module tb_fft_frame_ctrl;
  localparam int DW   = 16;
  localparam int LN   = 10;
  localparam int N    = 1 << LN;
  localparam int LAT  = 10;
  localparam int LN2  = 3;
  localparam int N2   = 1 << LN2;
  localparam int LAT2 = 2;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [LN-1:0] idx;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_ctrl_if #(.DATA_W(DW), .LOG2N(LN))  bus();
  fft_frame_ctrl_if #(.DATA_W(DW), .LOG2N(LN2)) bus2();

  logic                 core_enable, busy, core_enable2, busy2;
  logic signed [DW-1:0] xb_re, xb_im, Xb_re, Xb_im;
  logic signed [DW-1:0] xb2_re, xb2_im, Xb2_re, Xb2_im;
  logic [15:0]          fc, fc2;

  fft_frame_ctrl #(.DATA_W(DW), .LOG2N(LN), .CORE_LAT(LAT), .BITREV(0)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_enable(core_enable), .core_xb_re(xb_re), .core_xb_im(xb_im),
    .core_Xb_re(Xb_re), .core_Xb_im(Xb_im), .busy(busy), .frame_count(fc)
  );

  fft_frame_ctrl #(.DATA_W(DW), .LOG2N(LN2), .CORE_LAT(LAT2), .BITREV(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .core_enable(core_enable2), .core_xb_re(xb2_re), .core_xb_im(xb2_im),
    .core_Xb_re(Xb2_re), .core_Xb_im(Xb2_im), .busy(busy2), .frame_count(fc2)
  );

  // Core stand-ins: enable-gated delay lines of N+CORE_LAT stages.
  logic [2*DW-1:0] dly  [N+LAT];
  logic [2*DW-1:0] dly2 [N2+LAT2];
  always @(posedge clk) begin
    if (core_enable) begin
      dly[0] <= {xb_re, xb_im};
      for (int i = 1; i < N + LAT; i++) dly[i] <= dly[i-1];
    end
    if (core_enable2) begin
      dly2[0] <= {xb2_re, xb2_im};
      for (int i = 1; i < N2 + LAT2; i++) dly2[i] <= dly2[i-1];
    end
  end
  assign Xb_re  = dly[N+LAT-1][2*DW-1:DW];
  assign Xb_im  = dly[N+LAT-1][DW-1:0];
  assign Xb2_re = dly2[N2+LAT2-1][2*DW-1:DW];
  assign Xb2_im = dly2[N2+LAT2-1][DW-1:0];

  int    n_chk = 0;
  int    n_fail = 0;
  beat_t sbq[$];
  beat_t sbq2[$];
  logic [DW-1:0] fre [N];
  logic [DW-1:0] fim [N];
  int    rdy_mode = 0;
  int    en_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_s_ready",     {bus.s_ready}, 64'd0);
    chk("rst_core_enable", {core_enable}, 64'd0);
    chk("rst_core_xb_re",  {xb_re},       64'd0);
    chk("rst_core_xb_im",  {xb_im},       64'd0);
    chk("rst_m_valid",     {bus.m_valid}, 64'd0);
    chk("rst_m_re",        {bus.m_re},    64'd0);
    chk("rst_m_im",        {bus.m_im},    64'd0);
    chk("rst_m_index",     {bus.m_index}, 64'd0);
    chk("rst_m_last",      {bus.m_last},  64'd0);
    chk("rst_busy",        {busy},        64'd0);
    chk("rst_frame_count", {fc},          64'd0);
  endtask

  // Present one sample; returns with valid high and s_ready seen high, so the
  // handshake happens on the next rising edge.
  task automatic put_sample(input logic [DW-1:0] r, input logic [DW-1:0] i);
    int t = 0;
    @(posedge clk); #1;
    bus.s_valid = 1'b1;
    bus.s_re    = r;
    bus.s_im    = i;
    while (!bus.s_ready && t < 10000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.s_ready) chk("s_ready_timeout", {bus.s_ready}, 64'd1);
  endtask

  // kind 0: ramp re=j, im=-j; kind 1: constant 0x7FFF / 0x8000.
  task automatic send_frame(input int kind, input int gap);
    beat_t b;
    for (int j = 0; j < N; j++) begin
      logic [DW-1:0] r, i;
      r = (kind == 0) ? DW'(j)  : 16'h7FFF;
      i = (kind == 0) ? DW'(-j) : 16'h8000;
      put_sample(r, i);
      fre[j] = r;
      fim[j] = i;
      if (gap != 0) begin
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      b.re   = fre[k];
      b.im   = fim[k];
      b.idx  = LN'(k);
      b.last = (k == N - 1);
      sbq.push_back(b);
    end
  endtask

  task automatic wait_drain(input logic [15:0] fc_exp);
    int t = 0;
    chk("busy_after_load", {busy}, 64'd1);
    while (sbq.size() != 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_left", sbq.size(), 64'd0);
    @(negedge clk);
    chk("frame_count", {fc}, {fc_exp});
    chk("busy_idle", {busy}, 64'd0);
  endtask

  task automatic run_bitrev();
    int    t = 0;
    int    exp_re [N2] = '{0, 4, 2, 6, 1, 5, 3, 7};
    beat_t b;
    for (int j = 0; j < N2; j++) begin
      @(posedge clk); #1;
      bus2.s_valid = 1'b1;
      bus2.s_re    = DW'(j);
      bus2.s_im    = DW'(-j);
      t = 0;
      while (!bus2.s_ready && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (!bus2.s_ready) chk("s_ready2_timeout", {bus2.s_ready}, 64'd1);
    end
    @(posedge clk); #1;
    bus2.s_valid = 1'b0;
    for (int k = 0; k < N2; k++) begin
      b.re   = DW'(exp_re[k]);
      b.im   = DW'(-exp_re[k]);
      b.idx  = LN'(k);
      b.last = (k == N2 - 1);
      sbq2.push_back(b);
    end
    t = 0;
    while (sbq2.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("br_drain_left", sbq2.size(), 64'd0);
    @(negedge clk);
    chk("br_frame_count", {fc2}, 64'd1);
  endtask

  // Downstream ready: always 1, or the 1,1,0,0 stall pattern.
  initial begin
    int cyc = 0;
    bus.m_ready  = 1'b1;
    bus2.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.m_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4) < 2);
    end
  end

  // Monitor for the default instance: scoreboard, stall hold, core feed and
  // s_ready protocol.
  initial begin
    logic [63:0] cur_vec, prev_vec;
    logic        stall_prev = 1'b0, ld_prev = 1'b0, hs_prev = 1'b0;
    logic [31:0] hs_data = '0;
    logic        rdy_exp = 1'b0;
    int          phase = 0, ld_cnt = 0;
    beat_t       e;
    prev_vec = '0;
    forever begin
      @(negedge clk);
      cur_vec = {20'b0, bus.m_valid, bus.m_re, bus.m_im, bus.m_index, bus.m_last};
      if (stall_prev) chk("m_hold", cur_vec, prev_vec);
      if (bus.m_valid && bus.m_ready) begin
        if (sbq.size() == 0) chk("m_extra_beat", 64'd1, 64'd0);
        else begin
          e = sbq.pop_front();
          chk("m_re",    {bus.m_re},    {e.re});
          chk("m_im",    {bus.m_im},    {e.im});
          chk("m_index", {bus.m_index}, {e.idx});
          chk("m_last",  {bus.m_last},  {e.last});
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready && !rst;
      prev_vec   = cur_vec;

      if (ld_prev) begin
        chk("core_enable", {core_enable}, {hs_prev});
        chk("core_xb", {xb_re, xb_im}, hs_prev ? {32'h0, hs_data} : 64'h0);
        if (core_enable) en_cnt++;
      end
      ld_prev = bus.s_ready;
      hs_prev = bus.s_valid && bus.s_ready && !rst;
      hs_data = {bus.s_re, bus.s_im};

      chk("s_ready", {bus.s_ready}, {rdy_exp});
      if (rst) begin
        phase   = 0;
        ld_cnt  = 0;
        rdy_exp = 1'b0;
      end else begin
        if (phase == 0 && rdy_exp && bus.s_valid) begin
          if (ld_cnt == N - 1) begin
            phase  = 1;
            ld_cnt = 0;
          end else ld_cnt++;
        end else if (phase == 1 && bus.m_valid && bus.m_ready && bus.m_last) begin
          phase = 0;
        end
        rdy_exp = (phase == 0);
      end
    end
  end

  // Monitor for the bit-reversed instance.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (bus2.m_valid && bus2.m_ready) begin
        if (sbq2.size() == 0) chk("br_extra_beat", 64'd1, 64'd0);
        else begin
          e = sbq2.pop_front();
          chk("br_m_re",    {bus2.m_re},    {e.re});
          chk("br_m_im",    {bus2.m_im},    {e.im});
          chk("br_m_index", {bus2.m_index}, {e.idx[LN2-1:0]});
          chk("br_m_last",  {bus2.m_last},  {e.last});
        end
      end
    end
  end

  initial begin
    bus.s_valid  = 1'b0;
    bus.s_re     = '0;
    bus.s_im     = '0;
    bus2.s_valid = 1'b0;
    bus2.s_re    = '0;
    bus2.s_im    = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    run_bitrev();

    send_frame(0, 0);
    wait_drain(16'd1);

    en_cnt = 0;
    send_frame(0, 1);
    wait_drain(16'd2);
    chk("load_enable_cycles", en_cnt, N);

    rdy_mode = 1;
    send_frame(0, 0);
    wait_drain(16'd3);
    rdy_mode = 0;

    // Abandon a frame after 500 handshakes; rst wins over the pending one.
    for (int j = 0; j < 500; j++) put_sample(DW'(j), DW'(-j));
    @(posedge clk); #1;
    rst      = 1'b1;
    bus.s_re = DW'(500);
    bus.s_im = DW'(-500);
    @(posedge clk); #1;
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    @(negedge clk);
    check_reset();
    send_frame(0, 0);
    wait_drain(16'd1);

    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(0, 0);
    send_frame(1, 0);
    wait_drain(16'd2);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Parametrised frame controller that wraps a streaming FFT core (FFT_top-class: clock-enable `enable`, 16-bit complex in/out, fixed pipeline latency). It accepts complex samples over a valid/ready stream, feeds exactly one frame of N = 2^LOG2N samples to the core, flushes the core pipeline, and captures the N output bins into an internal buffer. It then replays the bins downstream over a valid/ready stream with bin index and end-of-frame marker, optionally un-scrambling bit-reversed core output.

## Interface
- DATA_W, 16, sample/bin component width (signed, two's complement)
- LOG2N, 10, log2 of frame length N
- CORE_LAT, 10, core cycles between the enable cycle of input sample N-1 and the first output bin
- BITREV, 0, 1 = read buffer in bit-reversed address order on output
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  controller accepts input (registered)
- s_re, s_im  in  DATA_W  input sample
- core_enable  out  1  clock-enable to core
- core_xb_re, core_xb_im  out  DATA_W  sample to core (registered)
- core_Xb_re, core_Xb_im  in  DATA_W  bin from core
- m_valid  out  1  output bin valid
- m_ready  in  1  downstream accepts
- m_re, m_im  out  DATA_W  output bin
- m_index  out  LOG2N  bin index of current beat
- m_last  out  1  high on the beat with m_index = N-1
- busy  out  1  high in any state except LOAD with zero samples taken
- frame_count  out  16  completed frames, wraps at 65535 -> 0

## Operation
- States: LOAD -> FLUSH -> CAPTURE -> DRAIN -> LOAD. Reset enters LOAD.
- LOAD: s_ready = 1. Each handshake (s_valid & s_ready) registers the sample onto core_xb_* and drives core_enable = 1 in the following cycle; cycles with no handshake drive core_enable = 0 and core_xb_* = 0. Sample counter 0..N-1; the handshake of sample N-1 moves to FLUSH, and s_ready drops the cycle after that handshake.
- FLUSH: core_enable = 1, core_xb_* = 0, CORE_LAT cycles.
- CAPTURE: core_enable = 1, core_xb_* = 0, N cycles; cycle j writes core_Xb_* into buffer address j. Buffer is 2^LOG2N x 2·DATA_W single-clock RAM, no reset.
- DRAIN: core_enable = 0. Read counter k = 0..N-1; buffer address = k (BITREV=0) or bit-reverse of k over LOG2N bits (BITREV=1). m_index = k. m_last = (k == N-1). On the m_last handshake: frame_count += 1, return to LOAD.
- No arithmetic on data; bins pass bit-exact.
- Reset mid-operation: current frame abandoned, counters cleared, buffer contents retained but never replayed.

## Timing
- Reset values: s_ready 0, core_enable 0, core_xb_* 0, m_valid 0, m_re/m_im 0, m_index 0, m_last 0, busy 0, frame_count 0. s_ready rises the first cycle after rst deasserts.
- Core contract: bin j is on core_Xb_* during cycle E + CORE_LAT + 1 + j, where E is the core_enable cycle carrying sample N-1 and core_enable stays high throughout.
- Output register stage: m_valid rises 1–2 cycles after entering DRAIN (RAM read latency 1). While m_valid & !m_ready, m_re/m_im/m_index/m_last hold stable. No bubbles are required under continuous m_ready; throughput of 1 beat/cycle is required.
- Minimum frame period with continuous valid/ready: N + CORE_LAT + N + N + ~3 cycles.
- s_ready is 0 in FLUSH, CAPTURE and DRAIN; s_valid is ignored there.
- rst has priority over every handshake in the same cycle.

## Test plan
- Bench core stub: enable-gated delay line of N+CORE_LAT stages, so that bin j equals input sample j. For defaults, feed ramp s_re = j, s_im = -j, j = 0..1023, continuous -> 1024 beats, m_re = k, m_im = -k, m_index = k, m_last only at k = 1023, frame_count = 1.
- LOG2N=3, BITREV=1, ramp 0..7 -> m_re sequence 0,4,2,6,1,5,3,7 with m_index 0..7.
- s_valid every other cycle for the default ramp -> output identical to the first scenario; exactly 1024 core_enable cycles during LOAD, core_enable low on the idle cycles.
- m_ready pattern 1,1,0,0 repeating during DRAIN -> no lost or duplicated beats; outputs stable across stalls; s_ready stays 0 until the m_last handshake.
- rst pulsed for 1 cycle after 500 LOAD handshakes -> all outputs at reset values the next cycle; the following full ramp frame is output correctly with frame_count = 1.
- Two back-to-back frames (ramp, then constant 0x7FFF/0x8000) -> s_ready = 1 the cycle after the first m_last handshake; second frame outputs all 0x7FFF/0x8000; frame_count = 2.
